// File: rtl/aes_pkg.sv
// aes_pkg: AES-128 constants (S-box, Rcon), GF(2^8) helpers and core FSM/round-counter types
package aes_pkg;
  typedef enum logic {IDLE, RUN} fsm_t;
  typedef logic [3:0] round_t;
  localparam logic [2047:0] SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16};
  localparam logic [0:9][7:0] RCON = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_FLAT[2047 - 8 * int'(b) -: 8];
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  // Rcon for round r (1..10); zero outside the valid range
  function automatic logic [7:0] rcon(input round_t r);
    return (r >= 4'd1 && r <= 4'd10) ? RCON[r - 4'd1] : 8'h00;
  endfunction
endpackage

// File: rtl/aes_round.sv
// aes_round: one combinational AES round (SubBytes, ShiftRows, MixColumns unless last_round, AddRoundKey); ports state_in, round_key, last_round -> state_out
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last_round,
  output logic [127:0] state_out
);
  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];
  always_comb begin
    for (int i = 0; i < 16; i++) sb[i] = sbox(state_in[127 - 8 * i -: 8]);
    // byte index 4*col+row; row r rotates left by r columns
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) sr[4 * c + r] = sb[4 * ((c + r) % 4) + r];
    for (int c = 0; c < 4; c++) begin
      mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
    state_out = '0;
    for (int i = 0; i < 16; i++)
      state_out[127 - 8 * i -: 8] = (last_round ? sr[i] : mc[i]) ^ round_key[127 - 8 * i -: 8];
  end
endmodule

// File: rtl/aes128_encrypt_core.sv
// aes128_encrypt_core: iterative AES-128 encryptor, one round per clock with on-the-fly key schedule.
// Ports: clk, reset (async active-low), data_valid_in/plain_text start a block, key_valid_in/cipher_key load
// the key, data_valid_out pulses with registered cipher_text. Define AES_BUSY_OUT_EN to add a busy output.
module aes128_encrypt_core
  import aes_pkg::*;
#(
  parameter int KEY_LEN       = 128,
  parameter int DATA_LEN      = 128,
  parameter int NUMS_OF_ROUND = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                data_valid_in,
  input  logic [DATA_LEN-1:0] plain_text,
  input  logic                key_valid_in,
  input  logic [KEY_LEN-1:0]  cipher_key,
  output logic                data_valid_out,
`ifdef AES_BUSY_OUT_EN
  output logic                busy,
`endif
  output logic [DATA_LEN-1:0] cipher_text
);
  fsm_t                fsm, fsm_next;
  round_t              round;
  logic [DATA_LEN-1:0] state, round_out;
  logic [KEY_LEN-1:0]  key_reg, rk, next_rk, eff_key;
  logic [31:0]         temp, n0, n1, n2, n3;
  logic                last;
  assign last    = round == round_t'(NUMS_OF_ROUND);
  assign eff_key = key_valid_in ? cipher_key : key_reg;
`ifdef AES_BUSY_OUT_EN
  assign busy = fsm == RUN;
`endif
  // next round key from the current one: RotWord, SubWord, Rcon, then XOR chain
  always_comb begin
    temp    = {sbox(rk[23:16]) ^ rcon(round), sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])};
    n0      = rk[127:96] ^ temp;
    n1      = rk[95:64] ^ n0;
    n2      = rk[63:32] ^ n1;
    n3      = rk[31:0] ^ n2;
    next_rk = {n0, n1, n2, n3};
  end
  aes_round u_round (
    .state_in  (state),
    .round_key (next_rk),
    .last_round(last),
    .state_out (round_out)
  );
  always_comb fsm_next = fsm == IDLE ? (data_valid_in ? RUN : IDLE) : (last ? IDLE : RUN);
  always_ff @(posedge clk or negedge reset)
    if (!reset) fsm <= IDLE;
    else fsm <= fsm_next;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= '0;
      rk             <= '0;
      key_reg        <= '0;
      round          <= '0;
      cipher_text    <= '0;
      data_valid_out <= 1'b0;
    end else begin
      data_valid_out <= 1'b0;
      if (fsm == IDLE) begin
        if (key_valid_in) key_reg <= cipher_key;
        if (data_valid_in) begin
          state <= plain_text ^ eff_key;
          rk    <= eff_key;
          round <= 4'd1;
        end
      end else begin
        state <= round_out;
        rk    <= next_rk;
        round <= last ? 4'd0 : round + 4'd1;
        if (last) begin
          cipher_text    <= round_out;
          data_valid_out <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_aes128_encrypt_core.sv
// tb_aes128_encrypt_core: vector table plus corner sequences checked against a byte-level AES model
module tb_aes128_encrypt_core;
  logic         clk = 0;
  logic         reset = 0;
  logic         data_valid_in = 0;
  logic [127:0] plain_text = '0;
  logic         key_valid_in = 0;
  logic [127:0] cipher_key = '0;
  logic         data_valid_out;
  logic [127:0] cipher_text;
`ifdef AES_BUSY_OUT_EN
  logic         busy;
`endif
  int checks = 0;
  int errors = 0;
  logic [127:0] last_ct = '0;
  logic [7:0] ref_sbox [256];
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] exp;
    int           mode;
  } vec_t;
  vec_t tbl [8];

  aes128_encrypt_core dut (
    .clk           (clk),
    .reset         (reset),
    .data_valid_in (data_valid_in),
    .plain_text    (plain_text),
    .key_valid_in  (key_valid_in),
    .cipher_key    (cipher_key),
    .data_valid_out(data_valid_out),
`ifdef AES_BUSY_OUT_EN
    .busy          (busy),
`endif
    .cipher_text   (cipher_text)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] k [176];
    logic [7:0] tmp [4];
    logic [7:0] rc = 8'h01;
    logic [127:0] res = '0;
    for (int i = 0; i < 16; i++) begin
      k[i] = key[127 - 8 * i -: 8];
      s[i] = pt[127 - 8 * i -: 8] ^ k[i];
    end
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) tmp[j] = k[i - 4 + j];
      if (i % 16 == 0) begin
        tmp[0] = ref_sbox[k[i - 3]] ^ rc;
        tmp[1] = ref_sbox[k[i - 2]];
        tmp[2] = ref_sbox[k[i - 1]];
        tmp[3] = ref_sbox[k[i - 4]];
        rc = gmul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) k[i + j] = k[i - 16 + j] ^ tmp[j];
    end
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = ref_sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4 * c + r] = t[4 * ((c + r) % 4) + r];
      if (rnd < 10) begin
        for (int i = 0; i < 16; i++) t[i] = s[i];
        for (int c = 0; c < 4; c++)
          for (int j = 0; j < 4; j++)
            s[4 * c + j] = gmul(8'h02, t[4 * c + j]) ^ gmul(8'h03, t[4 * c + (j + 1) % 4])
                         ^ t[4 * c + (j + 2) % 4] ^ t[4 * c + (j + 3) % 4];
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[16 * rnd + i];
    end
    for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
    return res;
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic count_pulses(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      @(negedge clk);
      if (data_valid_out) pulses++;
    end
  endtask

  // mode 0: both valids together, 1: key load then data alone, 2: data alone with stored key
  task automatic run_vec(input string nm, input logic [127:0] pt, input logic [127:0] key,
                         input logic [127:0] exp, input int mode);
    int cyc = 0;
    logic held = 1'b1;
    if (mode == 1) begin
      @(negedge clk);
      key_valid_in = 1;
      cipher_key = key;
      @(negedge clk);
      key_valid_in = 0;
      cipher_key = rand128();
      repeat (2) @(negedge clk);
    end
    @(negedge clk);
    data_valid_in = 1;
    plain_text = pt;
    key_valid_in = mode == 0;
    cipher_key = mode == 0 ? key : rand128();
    @(negedge clk);
    data_valid_in = 0;
    key_valid_in = 0;
    plain_text = rand128();
    do begin
      if (cipher_text !== last_ct) held = 1'b0;
      @(negedge clk);
      cyc++;
    end while (!data_valid_out && cyc < 30);
    chk({nm, " latency"}, 128'(cyc), 128'd10);
    chk({nm, " cipher_text"}, cipher_text, exp);
    chk({nm, " hold"}, 128'(held), 128'd1);
    @(negedge clk);
    chk({nm, " pulse_width"}, 128'(data_valid_out), 128'd0);
    last_ct = exp;
  endtask

  initial begin
    int cyc;
    int pulses;
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      ref_sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
    tbl[0] = '{C1_PT, C1_KEY, C1_CT, 0};
    tbl[1] = '{B_PT, B_KEY, B_CT, 0};
    tbl[2] = '{C1_PT, B_KEY, 128'h0, 1};
    tbl[3] = '{B_PT, B_KEY, B_CT, 2};
    for (int i = 4; i < 8; i++) tbl[i] = '{rand128(), rand128(), 128'h0, int'($urandom_range(0, 1))};
    for (int i = 2; i < 8; i++) if (i != 3) tbl[i].exp = aes_model(tbl[i].pt, tbl[i].key);

    repeat (5) @(negedge clk);
    chk("reset dvo", 128'(data_valid_out), 128'd0);
    chk("reset cipher_text", cipher_text, 128'h0);
    reset = 1;
    count_pulses(5, pulses);
    chk("no spurious dvo", 128'(pulses), 128'd0);

    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), tbl[i].pt, tbl[i].key, tbl[i].exp, tbl[i].mode);

    // start ignored while running; key_valid_in during RUN must not touch the key register
    @(negedge clk);
    data_valid_in = 1; key_valid_in = 1; plain_text = C1_PT; cipher_key = C1_KEY;
    @(negedge clk);
    data_valid_in = 0; key_valid_in = 0;
    repeat (3) @(negedge clk);
    data_valid_in = 1; key_valid_in = 1; plain_text = B_PT; cipher_key = B_KEY;
    @(negedge clk);
    data_valid_in = 0; key_valid_in = 0;
    cyc = 4;
    do begin
      @(negedge clk);
      cyc++;
    end while (!data_valid_out && cyc < 30);
    chk("busy latency", 128'(cyc), 128'd10);
    chk("busy cipher_text", cipher_text, C1_CT);
    count_pulses(14, pulses);
    chk("busy single pulse", 128'(pulses), 128'd0);
    last_ct = C1_CT;
    run_vec("stored key kept", C1_PT, 128'h0, C1_CT, 2);

    // reset mid-run aborts without a completion pulse
    @(negedge clk);
    data_valid_in = 1; key_valid_in = 1; plain_text = C1_PT; cipher_key = C1_KEY;
    @(negedge clk);
    data_valid_in = 0; key_valid_in = 0;
    repeat (4) @(negedge clk);
    #2 reset = 0;
    #1;
    chk("abort dvo", 128'(data_valid_out), 128'd0);
    chk("abort cipher_text", cipher_text, 128'h0);
    repeat (2) @(negedge clk);
    reset = 1;
    count_pulses(15, pulses);
    chk("abort no dvo", 128'(pulses), 128'd0);
    last_ct = 128'h0;
    run_vec("after abort", C1_PT, C1_KEY, C1_CT, 0);
    run_vec("after abort stored", B_PT, 128'h0, aes_model(B_PT, C1_KEY), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
